// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode tables and a line/frame total helper.
package vga_pkg;

   typedef struct packed {
      logic [15:0] active;
      logic [15:0] fp;
      logic [15:0] sync;
      logic [15:0] bp;
   } timing_t;

   // 640x480@60, 25.175 MHz pixel clock
   localparam timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
   localparam timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};
   // 800x600@60, 40 MHz pixel clock
   localparam timing_t SVGA_800X600_H = '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};
   localparam timing_t SVGA_800X600_V = '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23};

   function automatic int unsigned total(timing_t t);
      return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register with synchronous reset; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ce_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_i, ce_i};
      assign q_o         = d_i;
   end else begin : g_pipe
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] stage_q;
         logic [WIDTH-1:0] stage_d;

         if (gi == 0) begin : g_first
            assign stage_d = d_i;
         end else begin : g_next
            assign stage_d = g_stage[gi-1].stage_q;
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               stage_q <= RESET_VAL;
            end else if (ce_i) begin
               stage_q <= stage_d;
            end
         end
      end
      assign q_o = g_stage[DEPTH-1].stage_q;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, sync/DE decode and
// a clock-enabled delay chain that aligns sync/DE with downstream renderer latency.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE   = int'(VGA_640X480_H.active),
   parameter int   H_FP       = int'(VGA_640X480_H.fp),
   parameter int   H_SYNC     = int'(VGA_640X480_H.sync),
   parameter int   H_BP       = int'(VGA_640X480_H.bp),
   parameter int   V_ACTIVE   = int'(VGA_640X480_V.active),
   parameter int   V_FP       = int'(VGA_640X480_V.fp),
   parameter int   V_SYNC     = int'(VGA_640X480_V.sync),
   parameter int   V_BP       = int'(VGA_640X480_V.bp),
   parameter logic HS_POL     = 1'b0,
   parameter logic VS_POL     = 1'b0,
   parameter int   COORD_W    = 11,
   parameter int   PIPE_DELAY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   output logic [COORD_W-1:0] pixelx,
   output logic [COORD_W-1:0] pixely,
   output logic               active,
   output logic               line_start,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic               de
);

   localparam timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
   localparam timing_t V_TIM = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
   localparam int H_TOTAL = int'(total(H_TIM));
   localparam int V_TOTAL = int'(total(V_TIM));

   if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_width
      $error("vga_timing_gen: COORD_W=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d", COORD_W, H_TOTAL, V_TOTAL);
   end
   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
      $error("vga_timing_gen: porch and sync widths must be non-zero");
   end
   if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
      $error("vga_timing_gen: PIPE_DELAY=%0d out of range 0..15", PIPE_DELAY);
   end

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
   // Bit order {hsync, vsync, de}; idle is sync deasserted, DE low.
   localparam logic [2:0]         SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [2:0]         sync_q, sync_d, sync_dly;
   logic               active_raw, hs_raw, vs_raw, en;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (ce) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   assign active_raw = (x_q < H_ACT) && (y_q < V_ACT);
   assign hs_raw     = ((x_q >= HS_START) && (x_q < HS_END)) ? HS_POL : ~HS_POL;
   assign vs_raw     = ((y_q >= VS_START) && (y_q < VS_END)) ? VS_POL : ~VS_POL;
   assign sync_d     = {hs_raw, vs_raw, active_raw};

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         sync_q <= SYNC_IDLE;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         if (ce) begin
            sync_q <= sync_d;
         end
      end
   end

   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL (SYNC_IDLE)
   ) u_delay (
      .clk_i (clk),
      .rst_i (rst),
      .ce_i  (ce),
      .d_i   (sync_q),
      .q_o   (sync_dly)
   );

   // Strobes are suppressed while reset is held so they fire on the first ce after release.
   assign en          = ce & ~rst;
   assign pixelx      = x_q;
   assign pixely      = y_q;
   assign active      = en & active_raw;
   assign line_start  = en & (x_q == '0);
   assign frame_start = line_start & (y_q == '0);
   assign {hsync, vsync, de} = sync_dly;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480, a tiny 16x8 raster for frame-level behaviour, and 800x600 positive sync.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b1;

   always #5 clk = ~clk;

   // A: defaults (640x480, active-low, PIPE_DELAY=2)
   logic [10:0] pixelx_a, pixely_a;
   logic        active_a, line_start_a, frame_start_a, hsync_a, vsync_a, de_a;
   // B: tiny raster, H_TOTAL=16, V_TOTAL=8, COORD_W exactly full
   logic [3:0]  pixelx_b, pixely_b;
   logic        active_b, line_start_b, frame_start_b, hsync_b, vsync_b, de_b;
   // C: 800x600, active-high syncs, no extra delay
   logic [10:0] pixelx_c, pixely_c;
   logic        active_c, line_start_c, frame_start_c, hsync_c, vsync_c, de_c;

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst), .ce(ce), .pixelx(pixelx_a), .pixely(pixely_a), .active(active_a),
      .line_start(line_start_a), .frame_start(frame_start_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .COORD_W(4), .PIPE_DELAY(2)
   ) dut_b (
      .clk(clk), .rst(rst), .ce(ce), .pixelx(pixelx_b), .pixely(pixely_b), .active(active_b),
      .line_start(line_start_b), .frame_start(frame_start_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(int'(vga_pkg::SVGA_800X600_H.active)), .H_FP(int'(vga_pkg::SVGA_800X600_H.fp)),
      .H_SYNC(int'(vga_pkg::SVGA_800X600_H.sync)),     .H_BP(int'(vga_pkg::SVGA_800X600_H.bp)),
      .V_ACTIVE(int'(vga_pkg::SVGA_800X600_V.active)), .V_FP(int'(vga_pkg::SVGA_800X600_V.fp)),
      .V_SYNC(int'(vga_pkg::SVGA_800X600_V.sync)),     .V_BP(int'(vga_pkg::SVGA_800X600_V.bp)),
      .HS_POL(1'b1), .VS_POL(1'b1), .COORD_W(11), .PIPE_DELAY(0)
   ) dut_c (
      .clk(clk), .rst(rst), .ce(ce), .pixelx(pixelx_c), .pixely(pixely_c), .active(active_c),
      .line_start(line_start_c), .frame_start(frame_start_c), .hsync(hsync_c), .vsync(vsync_c), .de(de_c)
   );

   int n_checks = 0;
   int n_passed = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      else             n_passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Phase-1 measurements
   int de_cnt_a = 0, de_first_a = -1, act_cnt_a = 0;
   int hs_cnt_a = 0, hs_first_a = -1, ls_cnt_a = 0, ls_second_a = -1;
   int fs_cnt_b = 0, fs_second_b = -1, vs_cnt_b = 0, vs_first_b = -1;
   int de_cnt_b = 0, de_first_b = -1, hs_first_b = -1;
   int hs_cnt_c = 0, hs_first_c = -1, ls_second_c = -1;
   // Phase-2 measurements
   int fs_cnt_t = 0, fs_second_t = -1, hold_err = 0;
   logic [3:0] prev_x;
   logic [2:0] prev_sync;

   initial begin
      // Reset with ce held high: reset must win.
      rst = 1'b1; ce = 1'b1;
      tick(); tick();
      check("rst_pixelx_a", pixelx_a, 0);
      check("rst_pixely_a", pixely_a, 0);
      check("rst_hsync_a",  hsync_a, 1);
      check("rst_vsync_a",  vsync_a, 1);
      check("rst_de_a",     de_a, 0);
      check("rst_ls_a",     line_start_a, 0);
      check("rst_fs_a",     frame_start_a, 0);
      check("rst_hsync_c",  hsync_c, 0);
      check("rst_vsync_c",  vsync_c, 0);

      // Continuous ce: k counts cycles from reset release.
      rst = 1'b0;
      for (int k = 0; k < 1700; k++) begin
         #1;
         if (k == 0) begin
            check("fs_first_a", frame_start_a, 1);
            check("fs_first_b", frame_start_b, 1);
         end
         if (k < 800) begin
            if (de_a) begin de_cnt_a++; if (de_first_a < 0) de_first_a = k; end
            if (active_a) act_cnt_a++;
            if (!hsync_a) begin hs_cnt_a++; if (hs_first_a < 0) hs_first_a = k; end
         end
         if (line_start_a) begin ls_cnt_a++; if (k > 0 && ls_second_a < 0) ls_second_a = k; end
         if (frame_start_b) begin fs_cnt_b++; if (k > 0 && fs_second_b < 0) fs_second_b = k; end
         if (k < 128) begin
            if (!vsync_b) begin vs_cnt_b++; if (vs_first_b < 0) vs_first_b = k; end
            if (de_b) begin de_cnt_b++; if (de_first_b < 0) de_first_b = k; end
            if (!hsync_b && hs_first_b < 0) hs_first_b = k;
         end
         if (k < 1056 && hsync_c) begin hs_cnt_c++; if (hs_first_c < 0) hs_first_c = k; end
         if (line_start_c && k > 0 && ls_second_c < 0) ls_second_c = k;
         if (k == 15)  check("wrap_x15_b", pixelx_b, 15);
         if (k == 16) begin
            check("wrap_x0_b", pixelx_b, 0);
            check("wrap_y1_b", pixely_b, 1);
         end
         if (k == 127) check("last_y_b", pixely_b, 7);
         if (k == 128) begin
            check("frame_wrap_x_b", pixelx_b, 0);
            check("frame_wrap_y_b", pixely_b, 0);
         end
         tick();
      end
      check("de_first_a",   de_first_a, 3);
      check("de_count_a",   de_cnt_a, 640);
      check("active_cnt_a", act_cnt_a, 640);
      check("hs_first_a",   hs_first_a, 659);
      check("hs_width_a",   hs_cnt_a, 96);
      check("ls_count_a",   ls_cnt_a, 3);
      check("ls_period_a",  ls_second_a, 800);
      check("fs_count_b",   fs_cnt_b, 14);
      check("fs_period_b",  fs_second_b, 128);
      check("vs_first_b",   vs_first_b, 83);
      check("vs_width_b",   vs_cnt_b, 32);
      check("de_first_b",   de_first_b, 3);
      check("de_count_b",   de_cnt_b, 32);
      check("hs_first_b",   hs_first_b, 13);
      check("hs_first_c",   hs_first_c, 841);
      check("hs_width_c",   hs_cnt_c, 128);
      check("ls_period_c",  ls_second_c, 1056);

      // ce toggling 1/0: state advances only after ce=1 clocks.
      rst = 1'b1; ce = 1'b1;
      tick();
      rst = 1'b0;
      for (int j = 0; j < 600; j++) begin
         ce = (j % 2 == 0);
         #1;
         if (frame_start_b) begin fs_cnt_t++; if (j > 0 && fs_second_t < 0) fs_second_t = j; end
         if (j > 0 && (j % 2 == 0) && (pixelx_b != prev_x || {hsync_b, vsync_b, de_b} != prev_sync))
            hold_err++;
         if (j == 200) begin
            check("toggle_x_b", pixelx_b, 4);
            check("toggle_y_b", pixely_b, 6);
         end
         prev_x    = pixelx_b;
         prev_sync = {hsync_b, vsync_b, de_b};
         tick();
      end
      check("toggle_fs_count_b",  fs_cnt_t, 3);
      check("toggle_fs_period_b", fs_second_t, 256);
      check("toggle_hold_b",      hold_err, 0);

      // Reset in the middle of a vsync line.
      rst = 1'b1; ce = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 90; k++) tick();
      check("mid_x_b",     pixelx_b, 10);
      check("mid_y_b",     pixely_b, 5);
      check("mid_vsync_b", vsync_b, 0);
      rst = 1'b1;
      tick();
      check("mrst_x_b",     pixelx_b, 0);
      check("mrst_y_b",     pixely_b, 0);
      check("mrst_hsync_b", hsync_b, 1);
      check("mrst_vsync_b", vsync_b, 1);
      check("mrst_de_b",    de_b, 0);
      check("mrst_fs_b",    frame_start_b, 0);
      rst = 1'b0; ce = 1'b0;
      #1;
      check("mrst_fs_ce0_b", frame_start_b, 0);
      tick();
      check("mrst_hold_x_b", pixelx_b, 0);
      ce = 1'b1;
      #1;
      check("mrst_fs_ce1_b", frame_start_b, 1);
      tick();
      check("mrst_adv_x_b", pixelx_b, 1);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
